// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer:
// operation codes, sequencer state encoding and default sizing constants.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SCALE = 100;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDSUB = 3'd1,
    ST_MUL    = 3'd2,
    ST_DIV    = 3'd3,
    ST_FIX    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Add and subtract finish in a single adder pass; the rest go through muldiv_core.
  function automatic logic is_addsub(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/arith_sequencer_if.sv
// Request/response bundle between the control_unit (master) and the
// arithmetic sequencer (slave).
interface arith_sequencer_if #(parameter int WIDTH = 32);

  logic                    start;
  logic [1:0]              op;
  logic signed [WIDTH-1:0] operand_a;
  logic signed [WIDTH-1:0] operand_b;
  logic                    ready;
  logic                    busy;
  logic signed [WIDTH-1:0] result;
  logic                    result_valid;
  logic                    div_zero;
  logic                    overflow;

  modport master (
    output start, op, operand_a, operand_b,
    input  ready, busy, result, result_valid, div_zero, overflow
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output ready, busy, result, result_valid, div_zero, overflow
  );

endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: W-step shift-add multiply followed by a
// 2W-step restoring divide, both driven through one shared adder.
// The quotient replaces the dividend in the product register as it shifts.
// Optional macro ROUND_HALF_UP_EN: the quotient output is bumped by one when
// twice the final remainder reaches the divisor (round half away from zero).
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               div_phase,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  input  logic [WIDTH-1:0]   divisor_in,
  output logic               last,
  output logic [2*WIDTH-1:0] quotient
);

  localparam int CW = $clog2(2*WIDTH);
  localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_ITERS = CW'(2*WIDTH - 1);

  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   r_reg;
  logic [WIDTH-1:0]   m_reg;
  logic [WIDTH-1:0]   d_reg;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic               q_bit;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign r_shift = {r_reg, p_reg[2*WIDTH-1]};
  assign last    = (cnt_reg == '0);
  // Carry out of the subtract means no borrow, i.e. the divisor fits.
  assign q_bit   = add_sum[WIDTH+1];

  // Shared adder: accumulates the multiplicand or subtracts the divisor.
  always_comb begin
    add_a   = {1'b0, p_reg[2*WIDTH-1:WIDTH]};
    add_b   = {1'b0, m_reg};
    add_cin = 1'b0;
    if (div_phase) begin
      add_a   = r_shift;
      add_b   = ~{1'b0, d_reg};
      add_cin = 1'b1;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  // Operand load, then one multiplier bit or one quotient bit per step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_reg   <= '0;
      r_reg   <= '0;
      m_reg   <= '0;
      d_reg   <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      p_reg   <= {{WIDTH{1'b0}}, mplier_in};
      r_reg   <= '0;
      m_reg   <= mcand_in;
      d_reg   <= divisor_in;
      cnt_reg <= MUL_ITERS;
    end else if (step) begin
      // The counter reloads for the divide phase on the last multiply step.
      cnt_reg <= last ? DIV_ITERS : cnt_reg - CW'(1);
      if (div_phase) begin
        p_reg <= {p_reg[2*WIDTH-2:0], q_bit};
        r_reg <= q_bit ? add_sum[WIDTH-1:0] : r_shift[WIDTH-1:0];
      end else begin
        p_reg <= p_reg[0] ? {add_sum[WIDTH:0], p_reg[WIDTH-1:1]}
                          : {1'b0, p_reg[2*WIDTH-1:1]};
      end
    end
  end

`ifdef ROUND_HALF_UP_EN
  logic round_up;
  assign round_up = ({1'b0, r_reg, 1'b0} >= {2'b00, d_reg});
  assign quotient = p_reg + {{(2*WIDTH-1){1'b0}}, round_up};
`else
  assign quotient = p_reg;
`endif

endmodule

// File: rtl/arith_sequencer.sv
// Multi-cycle fixed-point arithmetic sequencer. Add/sub take one adder pass
// with saturation; mul/div run a multiply then a divide through muldiv_core,
// followed by sign fix-up and saturation.
// Optional macro ROUND_HALF_UP_EN (handled inside muldiv_core) rounds the
// mul/div quotient half away from zero instead of truncating.
module arith_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SCALE = DEFAULT_SCALE
) (
  input logic               clock,
  input logic               reset,
  arith_sequencer_if.slave  bus
);

  localparam logic [WIDTH-1:0]   RES_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   RES_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] Q_POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] Q_NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_reg, state_next;
  op_t                op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               sign_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               div_zero_reg;
  logic               overflow_reg;

  logic               accept;
  logic               div_by_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               core_load, core_step, core_last;
  logic [2*WIDTH-1:0] core_quotient;
  logic [WIDTH-1:0]   mcand, mplier, divisor;

  logic [WIDTH:0]     ext_a, ext_b, addsub_sum;
  logic               addsub_ovf;
  logic [WIDTH-1:0]   addsub_res;
  logic               fix_ovf;
  logic [WIDTH-1:0]   fix_res;

  logic               ready_next, busy_next, valid_next;

  assign accept      = (state_reg == ST_IDLE) && bus.start;
  assign div_by_zero = (bus.op == OP_DIV) && (bus.operand_b == '0);

  // Magnitudes as unsigned; the most negative value maps onto 2^(W-1).
  assign a_mag = bus.operand_a[WIDTH-1] ? (~bus.operand_a + WIDTH'(1)) : bus.operand_a;
  assign b_mag = bus.operand_b[WIDTH-1] ? (~bus.operand_b + WIDTH'(1)) : bus.operand_b;

  // MUL computes |a|*|b|/SCALE, DIV computes |a|*SCALE/|b|.
  assign mcand   = a_mag;
  assign mplier  = (bus.op == OP_DIV) ? WIDTH'(SCALE) : b_mag;
  assign divisor = (bus.op == OP_DIV) ? b_mag : WIDTH'(SCALE);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock      (clock),
    .reset      (reset),
    .load       (core_load),
    .step       (core_step),
    .div_phase  (state_reg == ST_DIV),
    .mcand_in   (mcand),
    .mplier_in  (mplier),
    .divisor_in (divisor),
    .last       (core_last),
    .quotient   (core_quotient)
  );

  // Add/sub on WIDTH+1 bits; the two top bits disagree exactly on overflow.
  assign ext_a      = {a_reg[WIDTH-1], a_reg};
  assign ext_b      = {b_reg[WIDTH-1], b_reg};
  assign addsub_sum = (op_reg == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);
  assign addsub_ovf = addsub_sum[WIDTH] ^ addsub_sum[WIDTH-1];
  assign addsub_res = addsub_ovf ? (addsub_sum[WIDTH] ? RES_MIN : RES_MAX)
                                 : addsub_sum[WIDTH-1:0];

  // Quotient magnitude is saturated against the limit for its sign, then negated.
  assign fix_ovf = sign_reg ? (core_quotient > Q_NEG_LIM) : (core_quotient > Q_POS_LIM);
  assign fix_res = fix_ovf ? (sign_reg ? RES_MIN : RES_MAX)
                           : (sign_reg ? (~core_quotient[WIDTH-1:0] + WIDTH'(1))
                                       : core_quotient[WIDTH-1:0]);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next state, core sequencing strobes and handshake outputs.
  always_comb begin
    state_next = state_reg;
    core_load  = 1'b0;
    core_step  = 1'b0;
    ready_next = 1'b0;
    busy_next  = 1'b1;
    valid_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (bus.start) begin
          if (is_addsub(bus.op)) begin
            state_next = ST_ADDSUB;
          end else if (div_by_zero) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_MUL;
            core_load  = 1'b1;
          end
        end
      end
      ST_ADDSUB: state_next = ST_DONE;
      ST_MUL: begin
        core_step = 1'b1;
        if (core_last) state_next = ST_DIV;
      end
      ST_DIV: begin
        core_step = 1'b1;
        if (core_last) state_next = ST_FIX;
      end
      ST_FIX: state_next = ST_DONE;
      ST_DONE: begin
        valid_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, flag clearing and result write-back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_reg       <= OP_ADD;
      a_reg        <= '0;
      b_reg        <= '0;
      sign_reg     <= 1'b0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        op_reg       <= op_t'(bus.op);
        a_reg        <= bus.operand_a;
        b_reg        <= bus.operand_b;
        sign_reg     <= !is_addsub(bus.op) && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
        div_zero_reg <= div_by_zero;
        overflow_reg <= 1'b0;
        if (div_by_zero) result_reg <= '0;
      end
      if (state_reg == ST_ADDSUB) begin
        result_reg   <= addsub_res;
        overflow_reg <= addsub_ovf;
      end
      if (state_reg == ST_FIX) begin
        result_reg   <= fix_res;
        overflow_reg <= fix_ovf;
      end
    end
  end

  assign bus.ready        = ready_next;
  assign bus.busy         = busy_next;
  assign bus.result_valid = valid_next;
  assign bus.result       = result_reg;
  assign bus.div_zero     = div_zero_reg;
  assign bus.overflow     = overflow_reg;

endmodule

// File: doc/arith_sequencer.md
Name: arith_sequencer

Overview:
Multi-cycle arithmetic sequencer between the calculator control_unit and a single shared W-bit adder/subtractor. It accepts one operation per request on signed fixed-point operands scaled by SCALE, with two decimal places. Add/sub take one pass through the adder. Mul and div are sequenced as a shift-add multiply phase followed by a restoring-divide phase, then sign fix-up and saturation. The control_unit drives start/op/operands and latches result on result_valid.

Parameters:
WIDTH, 32, operand/result width (signed two's complement, value = integer/SCALE)
SCALE, 100, fixed-point scale; constant multiplier/divisor for mul/div rescaling

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request strobe, sampled only when ready=1
op  in  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV
operand_a  in  WIDTH  signed left operand
operand_b  in  WIDTH  signed right operand
ready  out  1  high in IDLE; start accepted
busy  out  1  high from acceptance until result_valid cycle inclusive
result  out  WIDTH  signed result, held until next accepted start
result_valid  out  1  one-cycle pulse
div_zero  out  1  sticky with result; DIV with operand_b=0
overflow  out  1  sticky with result; result saturated

Behaviour:
- Reset (reset=0, async): state IDLE, ready=1, busy=0, result=0, result_valid=0, div_zero=0, overflow=0, all internal registers cleared. This applies mid-operation: the in-flight op is discarded and no result_valid is produced.
- Accept: start=1 and ready=1 at edge k. Capture op and operands. Clear div_zero/overflow. Store sign = a_neg XOR b_neg for MUL/DIV, and magnitudes |a|, |b| as WIDTH-bit unsigned (-2^(W-1) maps to 2^(W-1)).
- start while busy: ignored, with no queueing.
- States:
  - IDLE -> ADDSUB (op 0/1)
  - IDLE -> DONE (DIV with b=0)
  - IDLE -> MUL (op 2/3)
  - ADDSUB -> DONE
  - MUL -> DIV after WIDTH iterations
  - DIV -> FIX after 2*WIDTH iterations
  - FIX -> DONE
  - DONE -> IDLE
- result_valid is high in the DONE cycle only. ready is low in every state except IDLE.
- Latency, counted as edges from the accept edge to the edge that makes result_valid visible:
  - ADD/SUB: 2
  - div-by-zero: 1
  - MUL/DIV: 3*WIDTH+2
- ADDSUB: compute a±b on WIDTH+1 bits. If the result falls outside the signed WIDTH range, saturate to 2^(W-1)-1 or -2^(W-1) and set overflow.
- MUL phase: unsigned shift-add through the shared adder, one multiplier bit per cycle, producing a 2W-bit product P.
  - MUL: P = |a|*|b|, divisor D = SCALE.
  - DIV: P = |a|*SCALE, divisor D = |b|.
- DIV phase: restoring division of P by D, one quotient bit per cycle, 2W-bit quotient Q, truncation toward zero, remainder R kept.
- FIX: saturate and sign the quotient.
  - If sign=0 and Q > 2^(W-1)-1: saturate to 2^(W-1)-1 and set overflow.
  - If sign=1 and Q > 2^(W-1): saturate to -2^(W-1) and set overflow.
  - Otherwise result = sign ? -Q : Q.
  - A zero result with sign=1 yields 0.
- div_zero: result=0 and overflow=0.
- Counter: a single log2(2*WIDTH)-bit iteration counter, reloaded on each phase entry.

Optional Feature:
- Macro ROUND_HALF_UP_EN.
- Defined: in FIX, if 2*R >= D then Q=Q+1 before saturation and signing (round half away from zero). Latency is unchanged.
- Undefined: truncation toward zero; no rounding logic is built.

Decomposition:
- Shared package calc_pkg:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - state encoding (IDLE, ADDSUB, MUL, DIV, FIX, DONE)
  - default SCALE constant
- One natural sub-module, muldiv_core: iterative shift-add/restoring-subtract datapath with load, step and done, owning P/R/Q.
- arith_sequencer keeps the FSM, sign handling, saturation and outputs.

Test Plan (WIDTH=32, SCALE=100):
- ADD 900 + (-700) -> result_valid 2 edges after accept, result=200, flags 0; SUB -900 - 700 -> -1600.
- MUL 509*125 -> result=636 after 98 edges; MUL -900*-700 -> 6300.
- DIV -509/125 -> -407; DIV -9/125 -> -7; DIV 200/300 -> 66 without macro, 67 with ROUND_HALF_UP_EN.
- DIV 900/0 -> result=0, div_zero=1, latency 1; ADD 2147483647+1 -> 2147483647, overflow=1; MUL 2147483647*200 -> 2147483647, overflow=1.
- start pulsed during a MUL with different operands -> ignored; the single result_valid carries the original MUL result.
- reset=0 at iteration 40 of a DIV -> outputs cleared immediately, ready=1 after release, no result_valid; the next ADD 100+100 -> 200.
